// File: rtl/mac_pkt_rx_reader.sv
// MAC RX FIFO reader: 2-entry skid buffer, framing check, valid/ready output.
// Optional statistics counters are built when MAC_PKT_RX_STATS_EN is defined.
module mac_pkt_rx_reader (
  input  logic        clk_156m25,
  input  logic        reset_156m25,
  input  logic        pkt_rx_avail,
  output logic        pkt_rx_ren,
  input  logic [63:0] pkt_rx_data,
  input  logic        pkt_rx_val,
  input  logic        pkt_rx_sop,
  input  logic        pkt_rx_eop,
  input  logic [2:0]  pkt_rx_mod,
  input  logic        pkt_rx_err,
  output logic [63:0] out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic [2:0]  out_mod,
  output logic        out_err,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [31:0] stat_pkt_cnt,
  output logic [31:0] stat_err_cnt,
  output logic [15:0] stat_frm_cnt,
  output logic [47:0] stat_byte_cnt
);

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
  } word_t;

  typedef enum logic {
    S_IDLE,
    S_READ
  } state_t;

  state_t     r_state;
  state_t     w_state_nx;
  logic       r_ren_q;
  logic [1:0] r_occ;
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  word_t      r_mem [2];
  logic       r_in_pkt;

  logic       w_pop;
  logic       w_push;
  logic       w_frm_dup;
  logic [2:0] w_sum;
  word_t      w_word;
  word_t      w_head;

  assign w_pop     = out_val & out_rdy;
  assign w_frm_dup = pkt_rx_val & pkt_rx_sop & r_in_pkt;
  // Words outside a packet that lack SOP are dropped here.
  assign w_push    = pkt_rx_val & (pkt_rx_sop | r_in_pkt);
  assign w_sum     = {1'b0, r_occ} + {2'b00, r_ren_q}
                   - {2'b00, w_pop};

  always_comb begin
    w_word.data = pkt_rx_data;
    w_word.sop  = pkt_rx_sop;
    w_word.eop  = pkt_rx_eop;
    w_word.mod  = pkt_rx_eop ? pkt_rx_mod : 3'd0;
    w_word.err  = pkt_rx_err | w_frm_dup;
  end

  always_comb begin
    w_state_nx = r_state;
    pkt_rx_ren = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (pkt_rx_avail) w_state_nx = S_READ;
      end
      S_READ: begin
        pkt_rx_ren = (w_sum <= 3'd1);
        if (pkt_rx_val && pkt_rx_eop) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      r_state <= S_IDLE;
      r_ren_q <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ren_q <= pkt_rx_ren;
    end
  end

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      r_in_pkt <= 1'b0;
    end else if (pkt_rx_val) begin
      if (pkt_rx_sop) r_in_pkt <= ~pkt_rx_eop;
      else if (pkt_rx_eop) r_in_pkt <= 1'b0;
    end
  end

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign out_val  = (r_occ != 2'd0);
  assign out_data = w_head.data;
  assign out_sop  = w_head.sop;
  assign out_eop  = w_head.eop;
  assign out_mod  = w_head.mod;
  assign out_err  = w_head.err;

`ifdef MAC_PKT_RX_STATS_EN
  logic        r_pkt_err;
  logic        w_acc_err;
  logic        w_frm;
  logic [3:0]  w_bytes;
  logic [31:0] r_pkt_cnt;
  logic [31:0] r_err_cnt;
  logic [15:0] r_frm_cnt;
  logic [47:0] r_byte_cnt;

  assign w_frm     = w_frm_dup
                   | (pkt_rx_val & ~pkt_rx_sop & ~r_in_pkt);
  // SOP restarts the per-packet error accumulation.
  assign w_acc_err = (w_head.sop ? 1'b0 : r_pkt_err) | w_head.err;
  assign w_bytes   = !w_head.eop ? 4'd8 :
                     (w_head.mod == 3'd0) ? 4'd8 :
                     {1'b0, w_head.mod};

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      r_pkt_err  <= 1'b0;
      r_pkt_cnt  <= '0;
      r_err_cnt  <= '0;
      r_frm_cnt  <= '0;
      r_byte_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_byte_cnt <= r_byte_cnt + 48'(w_bytes);
        if (w_head.eop) begin
          r_pkt_cnt <= r_pkt_cnt + 32'd1;
          if (w_acc_err) r_err_cnt <= r_err_cnt + 32'd1;
          r_pkt_err <= 1'b0;
        end else begin
          r_pkt_err <= w_acc_err;
        end
      end
      if (w_frm) r_frm_cnt <= r_frm_cnt + 16'd1;
    end
  end

  assign stat_pkt_cnt  = r_pkt_cnt;
  assign stat_err_cnt  = r_err_cnt;
  assign stat_frm_cnt  = r_frm_cnt;
  assign stat_byte_cnt = r_byte_cnt;
`else
  assign stat_pkt_cnt  = '0;
  assign stat_err_cnt  = '0;
  assign stat_frm_cnt  = '0;
  assign stat_byte_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_pkt_rx_reader.sv
// Directed bench for mac_pkt_rx_reader: MAC FIFO model, sink, table vectors.
// Statistics expectations follow MAC_PKT_RX_STATS_EN (zero when undefined).
module tb_mac_pkt_rx_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pkt_rx_avail = 1'b0;
  logic        pkt_rx_ren;
  logic [63:0] pkt_rx_data = '0;
  logic        pkt_rx_val = 1'b0;
  logic        pkt_rx_sop = 1'b0;
  logic        pkt_rx_eop = 1'b0;
  logic [2:0]  pkt_rx_mod = '0;
  logic        pkt_rx_err = 1'b0;
  logic [63:0] out_data;
  logic        out_sop, out_eop, out_err, out_val;
  logic [2:0]  out_mod;
  logic        out_rdy = 1'b0;
  logic [31:0] stat_pkt_cnt, stat_err_cnt;
  logic [15:0] stat_frm_cnt;
  logic [47:0] stat_byte_cnt;

  always #5 clk = ~clk;

  mac_pkt_rx_reader dut (
    .clk_156m25   (clk),
    .reset_156m25 (rst),
    .pkt_rx_avail (pkt_rx_avail),
    .pkt_rx_ren   (pkt_rx_ren),
    .pkt_rx_data  (pkt_rx_data),
    .pkt_rx_val   (pkt_rx_val),
    .pkt_rx_sop   (pkt_rx_sop),
    .pkt_rx_eop   (pkt_rx_eop),
    .pkt_rx_mod   (pkt_rx_mod),
    .pkt_rx_err   (pkt_rx_err),
    .out_data     (out_data),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_mod      (out_mod),
    .out_err      (out_err),
    .out_val      (out_val),
    .out_rdy      (out_rdy),
    .stat_pkt_cnt (stat_pkt_cnt),
    .stat_err_cnt (stat_err_cnt),
    .stat_frm_cnt (stat_frm_cnt),
    .stat_byte_cnt(stat_byte_cnt)
  );

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
    logic        keep;
    logic        xerr;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
    int          cyc;
  } rx_t;

  vec_t tbl[$];
  vec_t src_q[$];
  rx_t  rx_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic ren_s = 1'b0;
  int   e_pkt = 0, e_err = 0, e_frm = 0, e_byte = 0;

  always @(posedge clk) cyc = cyc + 1;

  // MAC FIFO: a word follows one cycle after each sampled read enable.
  always @(posedge clk) begin
    vec_t w;
    #1;
    if (!rst && ren_s && src_q.size() > 0) begin
      w = src_q.pop_front();
      pkt_rx_val  = 1'b1;
      pkt_rx_data = w.d;
      pkt_rx_sop  = w.sop;
      pkt_rx_eop  = w.eop;
      pkt_rx_mod  = w.mod;
      pkt_rx_err  = w.err;
    end else begin
      pkt_rx_val  = 1'b0;
    end
    pkt_rx_avail = (src_q.size() != 0);
  end

  always @(negedge clk) begin
    rx_t r;
    ren_s = pkt_rx_ren;
    if (!rst && out_val && out_rdy) begin
      r.d   = out_data;
      r.sop = out_sop;
      r.eop = out_eop;
      r.mod = out_mod;
      r.err = out_err;
      r.cyc = cyc;
      rx_q.push_back(r);
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [63:0] d, input logic s, input logic e,
                     input logic [2:0] m, input logic er,
                     input logic k, input logic xe);
    vec_t v;
    v.d = d; v.sop = s; v.eop = e; v.mod = m; v.err = er;
    v.keep = k; v.xerr = xe;
    tbl.push_back(v);
  endtask

  task automatic load(input int first, input int last);
    for (int i = first; i <= last; i++) src_q.push_back(tbl[i]);
  endtask

  task automatic wait_rx(input int n, input bit tog);
    int k;
    k = 0;
    while (rx_q.size() < n && k < 500) begin
      @(posedge clk); #1;
      if (tog) out_rdy = ~out_rdy;
      k++;
    end
    chk("rx_timeout", 128'(rx_q.size() >= n), 128'(1));
    @(posedge clk); #1;
    out_rdy = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_rx(input string nm, input int first,
                          input int last);
    int idx;
    logic [69:0] e, a;
    idx = 0;
    for (int i = first; i <= last; i++) begin
      if (tbl[i].keep) begin
        e = {tbl[i].d, tbl[i].sop, tbl[i].eop,
             tbl[i].eop ? tbl[i].mod : 3'd0, tbl[i].xerr};
        if (idx < rx_q.size())
          a = {rx_q[idx].d, rx_q[idx].sop, rx_q[idx].eop,
               rx_q[idx].mod, rx_q[idx].err};
        else
          a = '1;
        chk($sformatf("%s_w%0d", nm, idx), 128'(a), 128'(e));
        idx++;
      end
    end
    chk($sformatf("%s_count", nm), 128'(rx_q.size()), 128'(idx));
  endtask

  task automatic check_stats(input string nm);
`ifdef MAC_PKT_RX_STATS_EN
    chk({nm, "_pkt"}, 128'(stat_pkt_cnt), 128'(e_pkt));
    chk({nm, "_err"}, 128'(stat_err_cnt), 128'(e_err));
    chk({nm, "_frm"}, 128'(stat_frm_cnt), 128'(e_frm));
    chk({nm, "_byte"}, 128'(stat_byte_cnt), 128'(e_byte));
`else
    chk({nm, "_stats0"},
        128'({stat_pkt_cnt, stat_err_cnt, stat_frm_cnt, stat_byte_cnt}),
        128'(0));
`endif
  endtask

  initial begin
    logic [69:0] snap;
    bit ren_bad, hold_bad;
    int k;

    for (int i = 0; i < 8; i++)
      add(64'h1000_0000_0000_0000 + 64'(i), i == 0, i == 7,
          (i == 7) ? 3'd0 : 3'd6, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      add(64'h2000_0000_0000_00A0 + 64'(i), i == 0, i == 2,
          (i == 2) ? 3'd5 : 3'd2, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      add(64'h3000_0000_0000_0000 + 64'(i * 17), i == 0, i == 7,
          (i == 7) ? 3'd4 : 3'd1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      add(64'h4000_0000_0000_0000 + 64'(i), i == 0 || i == 3, i == 5,
          3'd0, 1'b0, 1'b1, i == 3);
    for (int i = 0; i < 4; i++)
      add(64'h5000_0000_0000_0000 + 64'(i), i == 0, i == 3,
          3'd0, 1'b0, 1'b1, 1'b0);
    add(64'h6666_0000_0000_0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    add(64'h7000_0000_0000_0001, 1'b1, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0);
    add(64'h7000_0000_0000_0002, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ren", 128'(pkt_rx_ren), 128'(0));
    chk("rst_val", 128'(out_val), 128'(0));
    chk("rst_out",
        128'({out_data, out_sop, out_eop, out_mod, out_err}), 128'(0));
    check_stats("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    rx_q.delete();
    out_rdy = 1'b1;
    load(0, 7);
    wait_rx(8, 1'b0);
    check_rx("p64", 0, 7);
    if (rx_q.size() == 8)
      chk("p64_contig", 128'(rx_q[7].cyc - rx_q[0].cyc), 128'(7));
    e_pkt = 1; e_byte = 64;
    check_stats("p64");

    rx_q.delete();
    load(8, 10);
    wait_rx(3, 1'b1);
    check_rx("p21", 8, 10);
    e_pkt += 1; e_byte += 21;
    check_stats("p21");

    rx_q.delete();
    load(11, 18);
    k = 0;
    while (rx_q.size() < 3 && k < 200) begin
      @(posedge clk); #1; k++;
    end
    out_rdy = 1'b0;
    @(negedge clk);
    snap = {out_data, out_sop, out_eop, out_mod, out_err};
    chk("stall_val", 128'(out_val), 128'(1));
    ren_bad = 1'b0;
    hold_bad = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (pkt_rx_ren) ren_bad = 1'b1;
      if (!out_val ||
          snap !== {out_data, out_sop, out_eop, out_mod, out_err})
        hold_bad = 1'b1;
    end
    chk("stall_ren", 128'(ren_bad), 128'(0));
    chk("stall_hold", 128'(hold_bad), 128'(0));
    @(posedge clk); #1;
    out_rdy = 1'b1;
    wait_rx(8, 1'b0);
    check_rx("stall", 11, 18);
    e_pkt += 1; e_byte += 60;
    check_stats("stall");

    rx_q.delete();
    load(19, 24);
    wait_rx(6, 1'b0);
    check_rx("dupsop", 19, 24);
    e_pkt += 1; e_err += 1; e_frm += 1; e_byte += 48;
    check_stats("dupsop");

    rx_q.delete();
    out_rdy = 1'b0;
    load(25, 28);
    repeat (10) @(posedge clk);
    #1;
    chk("prerst_val", 128'(out_val), 128'(1));
    rst = 1'b1;
    src_q.delete();
    #1;
    chk("midrst_val", 128'(out_val), 128'(0));
    chk("midrst_out",
        128'({out_data, out_sop, out_eop, out_mod, out_err}), 128'(0));
    e_pkt = 0; e_err = 0; e_frm = 0; e_byte = 0;
    repeat (2) @(posedge clk);
    #1;
    check_stats("midrst");
    rst = 1'b0;
    rx_q.delete();
    out_rdy = 1'b1;
    load(29, 31);
    wait_rx(2, 1'b0);
    check_rx("errpkt", 29, 31);
    e_pkt = 1; e_err = 1; e_frm = 1; e_byte = 11;
    check_stats("errpkt");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
